// File: rtl/rng_pkg.sv
// Shared types and constants for the RNG controller and its round-robin arbiter.
package rng_pkg;

    localparam int LFSR_W = 8;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED_VAL = 8'hA5;

    typedef enum logic [1:0] {
        ST_SEED,
        ST_IDLE,
        ST_SHIFT,
        ST_PRESENT
    } state_t;

    // An all-zero seed would lock the LFSR up, so it is swapped for the fallback.
    function automatic logic [LFSR_W-1:0] safe_seed(
        input logic [LFSR_W-1:0] val,
        input logic [LFSR_W-1:0] fallback
    );
        return (val == '0) ? fallback : val;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection. The search begins at ptr (one past the last
// granted requester) and wraps from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    int               idx;
    logic             found;
    logic [PTR_W-1:0] sel;

    // Pick the first requesting index at or after ptr, wrapping around.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PTR_W'(idx);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_controller.sv
// Controller that shares an external 8-bit LFSR between several requesters:
// seeds it, runs a fixed number of shift steps per draw, presents the value
// to the granted requester and waits for its acknowledge.
module rng_controller
    import rng_pkg::*;
#(
    parameter int                NUM_REQ         = 4,
    parameter int                SHIFTS_PER_DRAW = 8,
    parameter logic [LFSR_W-1:0] DEFAULT_SEED    = DEFAULT_SEED_VAL
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed_val,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    output logic                rand_valid,
    output logic [LFSR_W-1:0]   rand_out,
    input  logic                rand_ack,
    output logic                lfsr_load_n,
    output logic                lfsr_shift,
    output logic [LFSR_W-1:0]   lfsr_load_val,
    input  logic [LFSR_W-1:0]   lfsr_q
);

    localparam int         PTR_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] LAST_SHIFT = 8'(SHIFTS_PER_DRAW - 1);

    state_t              state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    next_ptr;
    logic [7:0]          shift_cnt;
    logic                seed_pending;
    logic [LFSR_W-1:0]   pending_val;
    logic [NUM_REQ-1:0]  arb_grant;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (arb_grant)
    );

    // Search pointer for the next arbitration: one past whichever requester wins now.
    always_comb begin
        next_ptr = rr_ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign rand_out = rand_valid ? lfsr_q : '0;

    // Main sequencer: seeding, arbitration, shifting and presentation, with all outputs registered.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_SEED;
            grant         <= '0;
            rand_valid    <= 1'b0;
            lfsr_shift    <= 1'b0;
            lfsr_load_n   <= 1'b1;
            lfsr_load_val <= DEFAULT_SEED;
            seed_pending  <= 1'b0;
            pending_val   <= '0;
            rr_ptr        <= '0;
            shift_cnt     <= '0;
        end else begin
            if (seed_load && (state != ST_IDLE)) begin
                seed_pending <= 1'b1;
                pending_val  <= seed_val;
            end

            case (state)
                ST_SEED: begin
                    if (lfsr_load_n) begin
                        lfsr_load_n <= 1'b0;
                    end else begin
                        lfsr_load_n <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (seed_load) begin
                        lfsr_load_n   <= 1'b0;
                        lfsr_load_val <= safe_seed(seed_val, DEFAULT_SEED);
                        seed_pending  <= 1'b0;
                        state         <= ST_SEED;
                    end else if (seed_pending) begin
                        lfsr_load_n   <= 1'b0;
                        lfsr_load_val <= safe_seed(pending_val, DEFAULT_SEED);
                        seed_pending  <= 1'b0;
                        state         <= ST_SEED;
                    end else if (lfsr_q == '0) begin
                        lfsr_load_n   <= 1'b0;
                        lfsr_load_val <= DEFAULT_SEED;
                        state         <= ST_SEED;
                    end else if (|req) begin
                        grant      <= arb_grant;
                        rr_ptr     <= next_ptr;
                        lfsr_shift <= 1'b1;
                        shift_cnt  <= '0;
                        state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (shift_cnt == LAST_SHIFT) begin
                        lfsr_shift <= 1'b0;
                        rand_valid <= 1'b1;
                        state      <= ST_PRESENT;
                    end else begin
                        shift_cnt <= shift_cnt + 8'd1;
                    end
                end

                ST_PRESENT: begin
                    if (rand_ack) begin
                        grant      <= '0;
                        rand_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    lfsr_load_n   <= 1'b1;
                    lfsr_load_val <= DEFAULT_SEED;
                    state         <= ST_SEED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_controller.sv
// Self-checking bench for rng_controller with an 8-bit LFSR attached.
module tb_rng_controller;

    localparam int NREQ = 4;
    localparam int SPD  = 1;

    typedef struct packed {
        logic [3:0] grant;
        logic [7:0] value;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       seed_load;
    logic [7:0] seed_val;
    logic [3:0] req;
    logic [3:0] grant;
    logic       rand_valid;
    logic [7:0] rand_out;
    logic       rand_ack;
    logic       lfsr_load_n;
    logic       lfsr_shift;
    logic [7:0] lfsr_load_val;
    logic [7:0] lfsr_q;

    int         checks = 0;
    int         failures = 0;
    int         shift_run = 0;
    int         model_ptr = 0;
    logic [7:0] model_lfsr = 8'hA5;
    exp_t       exp_q[$];
    logic [3:0] rr_tab [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rng_controller #(
        .NUM_REQ         (NREQ),
        .SHIFTS_PER_DRAW (SPD),
        .DEFAULT_SEED    (8'hA5)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .seed_load     (seed_load),
        .seed_val      (seed_val),
        .req           (req),
        .grant         (grant),
        .rand_valid    (rand_valid),
        .rand_out      (rand_out),
        .rand_ack      (rand_ack),
        .lfsr_load_n   (lfsr_load_n),
        .lfsr_shift    (lfsr_shift),
        .lfsr_load_val (lfsr_load_val),
        .lfsr_q        (lfsr_q)
    );

    always #5 clock = ~clock;

    // The existing 8-bit LFSR: x^8+x^6+x^5+x^4+1, shifting right.
    always_ff @(posedge clock) begin
        if (!lfsr_load_n) begin
            lfsr_q <= lfsr_load_val;
        end else if (lfsr_shift) begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[4], lfsr_q[7:1]};
        end
    end

    // Every-cycle invariants plus the length of the current run of shift cycles.
    always @(negedge clock) begin
        if (reset_n) begin
            checks++;
            if (lfsr_shift && !lfsr_load_n) begin
                failures++;
                $display("[TB] FAIL shift_with_load at %0t: shift=%b load_n=%b must not both be active", $time, lfsr_shift, lfsr_load_n);
            end
            checks++;
            if (!rand_valid && rand_out !== 8'h00) begin
                failures++;
                $display("[TB] FAIL rand_out_idle at %0t: got %h, want 00", $time, rand_out);
            end
            if (lfsr_shift) shift_run++;
            else shift_run = 0;
        end
    end

    function automatic logic [7:0] model_step(input logic [7:0] v);
        return {^(v & 8'h1D), v[7:1]};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Predict grant and draw value for a request pattern and queue them.
    task automatic expect_draw(input logic [3:0] reqv);
        exp_t e;
        int   idx;
        e = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (model_ptr + k) % NREQ;
            if (reqv[idx] && e.grant == 4'b0000) begin
                e.grant[idx] = 1'b1;
                model_ptr    = (idx + 1) % NREQ;
            end
        end
        for (int s = 0; s < SPD; s++) model_lfsr = model_step(model_lfsr);
        e.value = model_lfsr;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(output logic ok, output int waited);
        waited = 0;
        while (rand_valid !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        ok = (rand_valid === 1'b1);
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req       = '0;
        rand_ack  = 1'b0;
        seed_load = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        model_lfsr = 8'hA5;
        model_ptr  = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        checks++; if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL reset_grant got %b want 0000", grant); end
        checks++; if (rand_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b want 0", rand_valid); end
        checks++; if (lfsr_shift !== 1'b0) begin failures++; $display("[TB] FAIL reset_shift got %b want 0", lfsr_shift); end
        checks++; if (lfsr_load_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_load_n got %b want 1", lfsr_load_n); end
        checks++; if (lfsr_load_val !== 8'hA5) begin failures++; $display("[TB] FAIL reset_load_val got %h want a5", lfsr_load_val); end
        checks++; if (rand_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_rand_out got %h want 00", rand_out); end
        reset_n = 1'b1;
        tick();
        checks++; if (lfsr_load_n !== 1'b0 || lfsr_load_val !== 8'hA5) begin failures++; $display("[TB] FAIL first_seed got load_n=%b val=%h want 0/a5", lfsr_load_n, lfsr_load_val); end
        tick();
        checks++; if (lfsr_load_n !== 1'b1) begin failures++; $display("[TB] FAIL seed_one_cycle got load_n=%b want 1", lfsr_load_n); end
        checks++; if (lfsr_q !== 8'hA5) begin failures++; $display("[TB] FAIL seeded_lfsr got %h want a5", lfsr_q); end
        model_lfsr = 8'hA5;
        model_ptr  = 0;
    endtask

    task automatic test_single_draw();
        exp_t e;
        logic ok;
        int   waited;
        req = 4'b0001;
        expect_draw(req);
        tick();
        checks++; if (grant !== 4'b0001) begin failures++; $display("[TB] FAIL single_grant got %b want 0001", grant); end
        checks++; if (lfsr_shift !== 1'b1 || rand_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_shift got shift=%b valid=%b want 1/0", lfsr_shift, rand_valid); end
        wait_valid(ok, waited);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL single_timeout rand_valid never rose");
        end else begin
            e = exp_q.pop_front();
            checks++; if (waited != SPD) begin failures++; $display("[TB] FAIL single_latency got %0d want %0d", waited, SPD); end
            checks++; if (rand_out !== e.value) begin failures++; $display("[TB] FAIL single_value got %h want %h", rand_out, e.value); end
            checks++; if (rand_out !== 8'h52) begin failures++; $display("[TB] FAIL single_value_a5 got %h want 52", rand_out); end
        end
        rand_ack = 1'b1;
        req      = '0;
        tick();
        rand_ack = 1'b0;
        checks++; if (rand_valid !== 1'b0 || grant !== 4'b0000) begin failures++; $display("[TB] FAIL single_ack got valid=%b grant=%b want 0/0000", rand_valid, grant); end
    endtask

    task automatic test_ack_ignored();
        exp_t e;
        logic ok;
        int   waited;
        req      = 4'b0100;
        rand_ack = 1'b1;
        expect_draw(req);
        tick();
        checks++; if (grant !== 4'b0100 || lfsr_shift !== 1'b1) begin failures++; $display("[TB] FAIL early_ack_grant got grant=%b shift=%b want 0100/1", grant, lfsr_shift); end
        wait_valid(ok, waited);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL early_ack_timeout rand_valid never rose");
        end else begin
            e = exp_q.pop_front();
            checks++; if (shift_run != SPD) begin failures++; $display("[TB] FAIL early_ack_shifts got %0d want %0d", shift_run, SPD); end
            checks++; if (grant !== e.grant || rand_out !== e.value) begin failures++; $display("[TB] FAIL early_ack_draw got %b/%h want %b/%h", grant, rand_out, e.grant, e.value); end
        end
        req = '0;
        tick();
        rand_ack = 1'b0;
        checks++; if (rand_valid !== 1'b0) begin failures++; $display("[TB] FAIL early_ack_release got valid=%b want 0", rand_valid); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        logic ok;
        int   waited;
        apply_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) expect_draw(req);
        for (int i = 0; i < 5; i++) begin
            wait_valid(ok, waited);
            checks++;
            if (!ok) begin
                failures++; $display("[TB] FAIL rr_timeout draw %0d", i);
            end else begin
                e = exp_q.pop_front();
                checks++; if (waited != 1 + SPD) begin failures++; $display("[TB] FAIL rr_latency draw %0d got %0d want %0d", i, waited, 1 + SPD); end
                checks++; if (grant !== rr_tab[i] || grant !== e.grant) begin failures++; $display("[TB] FAIL rr_grant draw %0d got %b want %b", i, grant, rr_tab[i]); end
                checks++; if (rand_out !== e.value) begin failures++; $display("[TB] FAIL rr_value draw %0d got %h want %h", i, rand_out, e.value); end
            end
            if (i == 4) req = '0;
            rand_ack = 1'b1;
            tick();
            rand_ack = 1'b0;
        end
    endtask

    task automatic test_seed_zero();
        exp_t e;
        logic ok;
        int   waited;
        seed_load = 1'b1;
        seed_val  = 8'h00;
        req       = 4'b0010;
        tick();
        seed_load = 1'b0;
        checks++; if (lfsr_load_n !== 1'b0 || lfsr_load_val !== 8'hA5) begin failures++; $display("[TB] FAIL zero_seed got load_n=%b val=%h want 0/a5", lfsr_load_n, lfsr_load_val); end
        checks++; if (grant !== 4'b0000) begin failures++; $display("[TB] FAIL seed_wins got grant=%b want 0000", grant); end
        model_lfsr = 8'hA5;
        expect_draw(req);
        tick();
        checks++; if (lfsr_load_n !== 1'b1 || lfsr_q !== 8'hA5) begin failures++; $display("[TB] FAIL zero_seed_loaded got load_n=%b q=%h want 1/a5", lfsr_load_n, lfsr_q); end
        wait_valid(ok, waited);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL after_seed_timeout rand_valid never rose");
        end else begin
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant || rand_out !== e.value) begin failures++; $display("[TB] FAIL after_seed_draw got %b/%h want %b/%h", grant, rand_out, e.grant, e.value); end
        end
        rand_ack = 1'b1;
        req      = '0;
        tick();
        rand_ack = 1'b0;
    endtask

    task automatic test_seed_pending();
        exp_t e;
        req = 4'b0100;
        expect_draw(req);
        tick();
        seed_load = 1'b1;
        seed_val  = 8'h11;
        tick();
        seed_val = 8'h3C;
        tick();
        seed_load = 1'b0;
        e = exp_q.pop_front();
        checks++; if (rand_valid !== 1'b1 || grant !== e.grant || rand_out !== e.value) begin failures++; $display("[TB] FAIL pending_draw got %b/%b/%h want 1/%b/%h", rand_valid, grant, rand_out, e.grant, e.value); end
        checks++; if (lfsr_load_n !== 1'b1) begin failures++; $display("[TB] FAIL pending_no_load got load_n=%b want 1", lfsr_load_n); end
        rand_ack = 1'b1;
        req      = '0;
        tick();
        rand_ack = 1'b0;
        tick();
        checks++; if (lfsr_load_n !== 1'b0 || lfsr_load_val !== 8'h3C) begin failures++; $display("[TB] FAIL pending_seed got load_n=%b val=%h want 0/3c", lfsr_load_n, lfsr_load_val); end
        tick();
        checks++; if (lfsr_q !== 8'h3C) begin failures++; $display("[TB] FAIL pending_lfsr got %h want 3c", lfsr_q); end
        model_lfsr = 8'h3C;
    endtask

    task automatic test_req_drop();
        exp_t e;
        logic ok;
        int   waited;
        req = 4'b1000;
        expect_draw(req);
        tick();
        checks++; if (grant !== 4'b1000) begin failures++; $display("[TB] FAIL drop_grant got %b want 1000", grant); end
        req = '0;
        wait_valid(ok, waited);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL drop_timeout rand_valid never rose");
        end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++; if (rand_valid !== 1'b1 || rand_out !== e.value || grant !== e.grant) begin failures++; $display("[TB] FAIL drop_hold cycle %0d got %b/%h/%b want 1/%h/%b", k, rand_valid, rand_out, grant, e.value, e.grant); end
                tick();
            end
        end
        rand_ack = 1'b1;
        tick();
        rand_ack = 1'b0;
        checks++; if (rand_valid !== 1'b0 || grant !== 4'b0000) begin failures++; $display("[TB] FAIL drop_ack got valid=%b grant=%b want 0/0000", rand_valid, grant); end
    endtask

    task automatic test_reset_mid_draw();
        exp_t e;
        logic ok;
        int   waited;
        req = 4'b0010;
        tick();
        reset_n = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || rand_valid !== 1'b0 || lfsr_shift !== 1'b0) begin failures++; $display("[TB] FAIL midreset got grant=%b valid=%b shift=%b want 0000/0/0", grant, rand_valid, lfsr_shift); end
        tick();
        reset_n = 1'b1;
        req     = '0;
        tick();
        checks++; if (lfsr_load_n !== 1'b0 || lfsr_load_val !== 8'hA5) begin failures++; $display("[TB] FAIL midreset_seed got load_n=%b val=%h want 0/a5", lfsr_load_n, lfsr_load_val); end
        tick();
        model_lfsr = 8'hA5;
        model_ptr  = 0;
        exp_q.delete();
        req = 4'b1111;
        expect_draw(req);
        wait_valid(ok, waited);
        checks++;
        if (!ok) begin
            failures++; $display("[TB] FAIL midreset_timeout rand_valid never rose");
        end else begin
            e = exp_q.pop_front();
            checks++; if (grant !== 4'b0001 || rand_out !== e.value) begin failures++; $display("[TB] FAIL midreset_restart got %b/%h want 0001/%h", grant, rand_out, e.value); end
        end
        rand_ack = 1'b1;
        req      = '0;
        tick();
        rand_ack = 1'b0;
        checks++; if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL leftover_expect got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        reset_n   = 1'b0;
        seed_load = 1'b0;
        seed_val  = 8'h00;
        req       = '0;
        rand_ack  = 1'b0;
        test_reset();
        test_single_draw();
        test_ack_ignored();
        test_round_robin();
        test_seed_zero();
        test_seed_pending();
        test_req_drop();
        test_reset_mid_draw();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
